// File: rtl/ahb_xbar_pkg.sv
// Shared encodings for the N-slave AHB-Lite interconnect and its default slave.
// Pure declarations; no timing.
package ahb_xbar_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int MAX_SLV = 8;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_lite_xbar_n_if.sv
// AHB-Lite bus bundle: master-facing side and broadcast slave-facing side.
// Modports are named from the interconnect's point of view on each side.
interface ahb_lite_xbar_n_if #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  // master side
  logic                        HSEL_M;
  logic [ADDR_W-1:0]           HADDR;
  logic [1:0]                  HTRANS;
  logic                        HWRITE;
  logic [2:0]                  HSIZE;
  logic [2:0]                  HBURST;
  logic [3:0]                  HPROT;
  logic                        HMASTLOCK;
  logic [DATA_W-1:0]           HWDATA;
  logic                        HREADY;
  logic                        HRESP;
  logic [DATA_W-1:0]           HRDATA;

  // slave side
  logic [NUM_SLV-1:0]          HSEL_S;
  logic [ADDR_W-1:0]           HADDR_S;
  logic [1:0]                  HTRANS_S;
  logic                        HWRITE_S;
  logic [2:0]                  HSIZE_S;
  logic [2:0]                  HBURST_S;
  logic [3:0]                  HPROT_S;
  logic                        HMASTLOCK_S;
  logic [DATA_W-1:0]           HWDATA_S;
  logic                        HREADY_S;
  logic [NUM_SLV-1:0]          HREADYOUT_S;
  logic [NUM_SLV-1:0]          HRESP_S;
  logic [NUM_SLV*DATA_W-1:0]   HRDATA_S;

  modport master (
    input  HSEL_M, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HREADY, HRESP, HRDATA
  );

  modport slave (
    output HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S,
           HMASTLOCK_S, HWDATA_S, HREADY_S,
    input  HREADYOUT_S, HRESP_S, HRDATA_S
  );

endinterface

// File: rtl/ahb_xbar_default_slave.sv
// Default slave: two-cycle ERROR for unclaimed active transfers; optional sticky error log (AHB_XBAR_ERRLOG_EN).
// Latency: response driven from state only, zero added cycles.
// Backpressure: holds HREADY low for the first ERROR cycle only.
module ahb_xbar_default_slave
  import ahb_xbar_pkg::*;
`ifdef AHB_XBAR_ERRLOG_EN
#(
  parameter int ADDR_W = 32
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hready,
  input  logic              def_sel,
  input  logic [1:0]        htrans,
  output logic              hreadyout,
  output logic              hresp
`ifdef AHB_XBAR_ERRLOG_EN
  ,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr
`endif
);

  ds_state_e state_q, state_d;
  logic      start;

  assign start = hready & def_sel & is_active(htrans);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state_q)
      DS_IDLE: if (start) state_d = DS_ERR1;
      DS_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = start ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

`ifdef AHB_XBAR_ERRLOG_EN
  logic capture;

  // A clear arriving with a fresh error still records that error.
  assign capture = (state_q == DS_IDLE) && start && (!err_valid || err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (capture) begin
      err_valid <= 1'b1;
      err_addr  <= haddr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ahb_lite_xbar_n.sv
// Single-master, NUM_SLV-slave AHB-Lite interconnect with base/mask decode and built-in default slave (log: AHB_XBAR_ERRLOG_EN).
// Latency: zero added cycles; only the data-phase select is registered.
// Backpressure: HREADY follows the slave owning the data phase and is broadcast as HREADY_S.
module ahb_lite_xbar_n
  import ahb_xbar_pkg::*;
#(
  parameter int                          NUM_SLV  = 4,
  parameter int                          ADDR_W   = 32,
  parameter int                          DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = {NUM_SLV{32'h0}},
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = {NUM_SLV{32'hF000_0000}}
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_lite_xbar_n_if.master mst,
  ahb_lite_xbar_n_if.slave  slv
`ifdef AHB_XBAR_ERRLOG_EN
  ,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr
`endif
);

  if (NUM_SLV < 1 || NUM_SLV > MAX_SLV) begin : g_bad_cfg
    $error("ahb_lite_xbar_n: NUM_SLV out of range");
  end

  logic [NUM_SLV-1:0] match;
  logic [NUM_SLV-1:0] win;
  logic [NUM_SLV-1:0] hsel;
  logic               def_sel;
  logic [NUM_SLV:0]   dsel;
  logic               hready;
  logic               hresp;
  logic [DATA_W-1:0]  hrdata;
  logic               def_hreadyout;
  logic               def_hresp;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      match[i] = (mst.HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W];
    end
  end

  // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
  assign win     = match & (~match + NUM_SLV'(1));
  assign hsel    = {NUM_SLV{mst.HSEL_M}} & win;
  assign def_sel = mst.HSEL_M & ~(|match);

  assign slv.HSEL_S      = hsel;
  assign slv.HADDR_S     = mst.HADDR;
  assign slv.HTRANS_S    = mst.HTRANS;
  assign slv.HWRITE_S    = mst.HWRITE;
  assign slv.HSIZE_S     = mst.HSIZE;
  assign slv.HBURST_S    = mst.HBURST;
  assign slv.HPROT_S     = mst.HPROT;
  assign slv.HMASTLOCK_S = mst.HMASTLOCK;
  assign slv.HWDATA_S    = mst.HWDATA;
  assign slv.HREADY_S    = hready;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      dsel <= '0;
    else if (hready) dsel <= {def_sel, hsel};
  end

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dsel[i]) begin
        hready = slv.HREADYOUT_S[i];
        hresp  = slv.HRESP_S[i];
        hrdata = slv.HRDATA_S[i*DATA_W +: DATA_W];
      end
    end
    if (dsel[NUM_SLV]) begin
      hready = def_hreadyout;
      hresp  = def_hresp;
      hrdata = '0;
    end
  end

  assign mst.HREADY = hready;
  assign mst.HRESP  = hresp;
  assign mst.HRDATA = hrdata;

  ahb_xbar_default_slave
`ifdef AHB_XBAR_ERRLOG_EN
  #(
    .ADDR_W (ADDR_W)
  )
`endif
  u_def_slv (
    .clk       (HCLK),
    .rst       (HRESET),
    .hready    (hready),
    .def_sel   (def_sel),
    .htrans    (mst.HTRANS),
    .hreadyout (def_hreadyout),
    .hresp     (def_hresp)
`ifdef AHB_XBAR_ERRLOG_EN
    ,
    .haddr     (mst.HADDR),
    .err_clr   (err_clr),
    .err_valid (err_valid),
    .err_addr  (err_addr)
`endif
  );

endmodule

// File: tb/tb_ahb_lite_xbar_n.sv
// Bench for ahb_lite_xbar_n: scoreboarded transfers against simple wait-state slave models,
// plus two overlapping-map instances for decode priority.
module tb_ahb_lite_xbar_n;

  localparam logic [127:0] MAIN_BASE = {32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [127:0] MAIN_MASK = {4{32'hF000_0000}};
  localparam logic [127:0] OV1_MASK  = {32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'hF000_0000};
  localparam logic [127:0] OV2_MASK  = {32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [127:0] OV_BASE   = {32'h6000_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000};

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    logic        chk_data;
    int          waits;
  } exp_t;

  logic HCLK;
  logic HRESET;

  ahb_lite_xbar_n_if #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32)) bus ();
  ahb_lite_xbar_n_if #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32)) ov1_bus ();
  ahb_lite_xbar_n_if #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32)) ov2_bus ();

`ifdef AHB_XBAR_ERRLOG_EN
  logic        err_clr;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        ov1_ev, ov2_ev;
  logic [31:0] ov1_ea, ov2_ea;
`endif

  ahb_lite_xbar_n #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .SLV_BASE(MAIN_BASE), .SLV_MASK(MAIN_MASK)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .mst(bus.master), .slv(bus.slave)
`ifdef AHB_XBAR_ERRLOG_EN
    , .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr)
`endif
  );

  ahb_lite_xbar_n #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .SLV_BASE(OV_BASE), .SLV_MASK(OV1_MASK)) u_ov1 (
    .HCLK(HCLK), .HRESET(HRESET), .mst(ov1_bus.master), .slv(ov1_bus.slave)
`ifdef AHB_XBAR_ERRLOG_EN
    , .err_clr(1'b0), .err_valid(ov1_ev), .err_addr(ov1_ea)
`endif
  );

  ahb_lite_xbar_n #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .SLV_BASE(OV_BASE), .SLV_MASK(OV2_MASK)) u_ov2 (
    .HCLK(HCLK), .HRESET(HRESET), .mst(ov2_bus.master), .slv(ov2_bus.slave)
`ifdef AHB_XBAR_ERRLOG_EN
    , .err_clr(1'b0), .err_valid(ov2_ev), .err_addr(ov2_ea)
`endif
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Slave models: programmable wait states and read data per port.
  int unsigned wait_cfg [4];
  logic [31:0] rd_cfg   [4];
  int unsigned cnt      [4];

  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.HREADY_S && bus.HSEL_S[i] && bus.HTRANS_S[1]) cnt[i] <= wait_cfg[i];
      else if (cnt[i] != 0)                                  cnt[i] <= cnt[i] - 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.HREADYOUT_S[i]      = (cnt[i] == 0);
      bus.HRESP_S[i]          = 1'b0;
      bus.HRDATA_S[i*32 +: 32] = rd_cfg[i];
    end
  end

  // Scoreboard: entries pushed when an active address phase is driven.
  exp_t sb[$];
  exp_t cur;
  logic dp_active = 1'b0;
  int   lowcnt    = 0;

  initial forever begin
    @(negedge HCLK);
    if (HRESET) begin
      sb.delete();
      dp_active = 1'b0;
    end else begin
      if (dp_active) begin
        if (!bus.HREADY) begin
          lowcnt++;
          chk("wait_resp", bus.HRESP, cur.resp);
        end else begin
          if (cur.chk_data) chk("hrdata", bus.HRDATA, cur.rdata);
          chk("hresp", bus.HRESP, cur.resp);
          chk("waits", lowcnt, cur.waits);
          dp_active = 1'b0;
        end
      end
      if (bus.HREADY && bus.HSEL_M && bus.HTRANS[1] && sb.size() != 0) begin
        cur       = sb.pop_front();
        dp_active = 1'b1;
        lowcnt    = 0;
      end
    end
  end

  logic [31:0] pend_wdata = 32'h0;

  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [1:0] tr,
                      input logic [3:0] exp_hsel, input logic exp_resp,
                      input logic [31:0] exp_rd, input int exp_wait);
    logic [31:0] hw;
    int k;
    @(posedge HCLK); #1;
    hw            = pend_wdata;
    bus.HSEL_M    = 1'b1;
    bus.HADDR     = addr;
    bus.HTRANS    = tr;
    bus.HWRITE    = wr;
    bus.HSIZE     = 3'b010;
    bus.HBURST    = 3'b000;
    bus.HPROT     = 4'b0011;
    bus.HMASTLOCK = 1'b0;
    bus.HWDATA    = hw;
    pend_wdata    = wr ? (addr ^ 32'hDEAD_BEEF) : 32'h0;
    if (tr[1]) sb.push_back('{exp_rd, exp_resp, !wr, exp_wait});
    @(negedge HCLK);
    chk("hsel", bus.HSEL_S, exp_hsel);
    chk("haddr_s", bus.HADDR_S, addr);
    chk("htrans_s", bus.HTRANS_S, tr);
    chk("hwdata_s", bus.HWDATA_S, hw);
    chk("ctrl_s", {bus.HWRITE_S, bus.HSIZE_S, bus.HBURST_S, bus.HPROT_S, bus.HMASTLOCK_S},
        {wr, 3'b010, 3'b000, 4'b0011, 1'b0});
    k = 0;
    while (!bus.HREADY && k < 100) begin
      @(negedge HCLK);
      k++;
    end
    if (!bus.HREADY) chk("accept_timeout", bus.HREADY, 1'b1);
  endtask

  task automatic drain();
    int k;
    @(posedge HCLK); #1;
    bus.HSEL_M = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = pend_wdata;
    pend_wdata = 32'h0;
    k = 0;
    do begin
      @(negedge HCLK);
      k++;
    end while ((sb.size() != 0 || dp_active) && k < 200);
    if (sb.size() != 0 || dp_active) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic ov_chk(input logic [31:0] addr, input logic [3:0] exp1, input logic [3:0] exp2);
    ov1_bus.HADDR = addr;
    ov2_bus.HADDR = addr;
    #1;
    chk("ov1_hsel", ov1_bus.HSEL_S, exp1);
    chk("ov2_hsel", ov2_bus.HSEL_S, exp2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    bus.HSEL_M = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = '0; bus.HBURST = '0; bus.HPROT = '0; bus.HMASTLOCK = 1'b0; bus.HWDATA = '0;
    ov1_bus.HSEL_M = 1'b1; ov1_bus.HADDR = '0; ov1_bus.HTRANS = 2'b00; ov1_bus.HWRITE = 1'b0;
    ov1_bus.HSIZE = '0; ov1_bus.HBURST = '0; ov1_bus.HPROT = '0; ov1_bus.HMASTLOCK = 1'b0;
    ov1_bus.HWDATA = '0; ov1_bus.HREADYOUT_S = '1; ov1_bus.HRESP_S = '0; ov1_bus.HRDATA_S = '0;
    ov2_bus.HSEL_M = 1'b1; ov2_bus.HADDR = '0; ov2_bus.HTRANS = 2'b00; ov2_bus.HWRITE = 1'b0;
    ov2_bus.HSIZE = '0; ov2_bus.HBURST = '0; ov2_bus.HPROT = '0; ov2_bus.HMASTLOCK = 1'b0;
    ov2_bus.HWDATA = '0; ov2_bus.HREADYOUT_S = '1; ov2_bus.HRESP_S = '0; ov2_bus.HRDATA_S = '0;
`ifdef AHB_XBAR_ERRLOG_EN
    err_clr = 1'b0;
`endif
    wait_cfg = '{0, 0, 2, 0};
    rd_cfg   = '{32'h0000_1111, 32'h1111_2222, 32'hA5A5_1234, 32'h3333_CCCC};

    #1;
    chk("rst_hready", bus.HREADY, 1'b1);
    chk("rst_hresp", bus.HRESP, 1'b0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    chk("rst_hsel", bus.HSEL_S, 4'b0000);
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Read from S2 with two wait states.
    xfer(32'h4000_0010, 1'b0, 2'b10, 4'b0100, 1'b0, 32'hA5A5_1234, 2);
    drain();
    chk("idle_hsel", bus.HSEL_S, 4'b0000);

    // Back-to-back write S0 then read S1, zero wait.
    xfer(32'h0000_0004, 1'b1, 2'b10, 4'b0001, 1'b0, 32'h0, 0);
    xfer(32'h2000_0000, 1'b0, 2'b10, 4'b0010, 1'b0, 32'h1111_2222, 0);
    drain();

    // Unmapped: two-cycle ERROR, then OKAY.
    xfer(32'hF000_0000, 1'b0, 2'b10, 4'b0000, 1'b1, 32'h0, 1);
    drain();
    @(negedge HCLK);
    chk("post_err_hready", bus.HREADY, 1'b1);
    chk("post_err_hresp", bus.HRESP, 1'b0);

    // Back-to-back unmapped, then straight into a mapped read.
    xfer(32'hF000_0000, 1'b0, 2'b10, 4'b0000, 1'b1, 32'h0, 1);
    xfer(32'hF000_0004, 1'b0, 2'b11, 4'b0000, 1'b1, 32'h0, 1);
    xfer(32'h4000_0010, 1'b0, 2'b10, 4'b0100, 1'b0, 32'hA5A5_1234, 2);
    drain();

    // IDLE transfer to unmapped space: zero-wait OKAY.
    @(posedge HCLK); #1;
    bus.HSEL_M = 1'b1; bus.HADDR = 32'hF000_0000; bus.HTRANS = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      chk("idle_unm_hready", bus.HREADY, 1'b1);
      chk("idle_unm_hresp", bus.HRESP, 1'b0);
    end
    drain();

    // Overlapping maps.
    ov_chk(32'h6000_0000, 4'b0010, 4'b0001);
    ov_chk(32'h0000_0000, 4'b0001, 4'b0001);
    ov_chk(32'hF000_0000, 4'b0010, 4'b0001);
    ov_chk(32'h4000_0000, 4'b0010, 4'b0001);

    // Reset while S3 stalls the data phase.
    wait_cfg[3] = 20;
    xfer(32'h6000_0000, 1'b0, 2'b10, 4'b1000, 1'b0, 32'h3333_CCCC, 20);
    @(posedge HCLK); #1;
    bus.HSEL_M = 1'b0; bus.HTRANS = 2'b00;
    repeat (2) @(negedge HCLK);
    chk("stall_hready", bus.HREADY, 1'b0);
    #1 HRESET = 1'b1;
    #1;
    chk("arst_hready", bus.HREADY, 1'b1);
    chk("arst_hresp", bus.HRESP, 1'b0);
    chk("arst_hrdata", bus.HRDATA, 32'h0);
    @(negedge HCLK);
    #1 HRESET = 1'b0;
    repeat (25) @(negedge HCLK);

`ifdef AHB_XBAR_ERRLOG_EN
    chk("errlog_rst_valid", err_valid, 1'b0);
    xfer(32'hE000_0008, 1'b0, 2'b10, 4'b0000, 1'b1, 32'h0, 1);
    drain();
    chk("errlog_valid", err_valid, 1'b1);
    chk("errlog_addr", err_addr, 32'hE000_0008);
    xfer(32'hF000_0000, 1'b0, 2'b10, 4'b0000, 1'b1, 32'h0, 1);
    drain();
    chk("errlog_sticky", err_addr, 32'hE000_0008);
    @(posedge HCLK); #1 err_clr = 1'b1;
    @(posedge HCLK); #1 err_clr = 1'b0;
    @(negedge HCLK);
    chk("errlog_clr", err_valid, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
